// File: rtl/ccr_intr_ctrl.sv
// CCR write arbiter with a shadow flag stack for interrupt entry (push) and RTI (pop).
// Optional build macro CCR_CLEAR_ON_INTR_EN: the SAVE cycle also clears the CCR.
module ccr_intr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_flag_en,
  input  logic [3:0]    alu_flag_mask,
  input  logic [3:0]    alu_flags,
  input  logic [3:0]    ccr_q,
  input  logic          intr_req,
  input  logic          rti_req,
  output logic          ccr_flag_en,
  output logic [3:0]    ccr_flag_mask,
  output logic [3:0]    ccr_flags,
  output logic          intr_ack,
  output logic          rti_done,
  output logic          busy,
  output logic [PW-1:0] nest_level,
  output logic          ovf_err,
  output logic          unf_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_sp;
  logic [3:0]    r_stack [DEPTH];
  logic          r_ovf_err;
  logic          r_unf_err;

  logic          w_full;
  logic          w_empty;
  logic          w_ovf_set;
  logic [3:0]    w_top;

  assign w_full  = (r_sp == PW'(DEPTH));
  assign w_empty = (r_sp == '0);

  // Top-of-stack read: entry sp-1.
  always_comb begin
    w_top = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i + 1) == r_sp) begin
        w_top = r_stack[i];
      end
    end
  end

  // Next state; RTI wins over interrupt entry.
  always_comb begin
    w_state_nxt = r_state;
    w_ovf_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rti_req) begin
          w_state_nxt = ST_RESTORE;
        end else if (intr_req && !w_full) begin
          w_state_nxt = ST_SAVE;
        end else if (intr_req) begin
          w_ovf_set = 1'b1;
        end
      end
      ST_SAVE:    w_state_nxt = ST_IDLE;
      ST_RESTORE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ccr_flag_en   = 1'b0;
    ccr_flag_mask = 4'b0000;
    ccr_flags     = 4'b0000;
    intr_ack      = 1'b0;
    rti_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ccr_flag_en   = alu_flag_en;
        ccr_flag_mask = alu_flag_mask;
        ccr_flags     = alu_flags;
      end
      ST_SAVE: begin
        intr_ack = 1'b1;
`ifdef CCR_CLEAR_ON_INTR_EN
        ccr_flag_en   = 1'b1;
        ccr_flag_mask = 4'b1111;
        ccr_flags     = 4'b0000;
`else
        ccr_flag_en   = 1'b0;
`endif
      end
      ST_RESTORE: begin
        rti_done = 1'b1;
        if (!w_empty) begin
          ccr_flag_en   = 1'b1;
          ccr_flag_mask = 4'b1111;
          ccr_flags     = w_top;
        end
      end
      default: begin
        ccr_flag_en = 1'b0;
      end
    endcase
    // Reset aborts any in-flight operation, including its pulse and CCR write.
    if (rst) begin
      ccr_flag_en   = 1'b0;
      ccr_flag_mask = 4'b0000;
      ccr_flags     = 4'b0000;
      intr_ack      = 1'b0;
      rti_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sp      <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ovf_set) begin
        r_ovf_err <= 1'b1;
      end
      if (r_state == ST_SAVE) begin
        r_sp <= r_sp + PW'(1);
      end
      if (r_state == ST_RESTORE) begin
        if (w_empty) begin
          r_unf_err <= 1'b1;
        end else begin
          r_sp <= r_sp - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= 4'b0000;
      end
    end else if (r_state == ST_SAVE) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (PW'(i) == r_sp) begin
          r_stack[i] <= ccr_q;
        end
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign nest_level = r_sp;
  assign ovf_err    = r_ovf_err;
  assign unf_err    = r_unf_err;

endmodule

// File: tb/tb_ccr_intr_ctrl.sv
// Randomized self-checking bench for ccr_intr_ctrl against a queue-based flag stack model.
module tb_ccr_intr_ctrl;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_flag_en;
  logic [3:0]    alu_flag_mask;
  logic [3:0]    alu_flags;
  logic [3:0]    ccr_q;
  logic          intr_req;
  logic          rti_req;
  logic          ccr_flag_en;
  logic [3:0]    ccr_flag_mask;
  logic [3:0]    ccr_flags;
  logic          intr_ack;
  logic          rti_done;
  logic          busy;
  logic [PW-1:0] nest_level;
  logic          ovf_err;
  logic          unf_err;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_stack [$];
  bit         m_ovf;
  bit         m_unf;

  always #5 clk = ~clk;

  ccr_intr_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_flag_en   (alu_flag_en),
    .alu_flag_mask (alu_flag_mask),
    .alu_flags     (alu_flags),
    .ccr_q         (ccr_q),
    .intr_req      (intr_req),
    .rti_req       (rti_req),
    .ccr_flag_en   (ccr_flag_en),
    .ccr_flag_mask (ccr_flag_mask),
    .ccr_flags     (ccr_flags),
    .intr_ack      (intr_ack),
    .rti_done      (rti_done),
    .busy          (busy),
    .nest_level    (nest_level),
    .ovf_err       (ovf_err),
    .unf_err       (unf_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_alu();
    alu_flag_en   = 1'($urandom_range(0, 1));
    alu_flag_mask = 4'($urandom);
    alu_flags     = 4'($urandom);
  endtask

  task automatic check_passthru(input string tag);
    check_eq({tag, "_en"},   32'(ccr_flag_en),   32'(alu_flag_en));
    check_eq({tag, "_mask"}, 32'(ccr_flag_mask), 32'(alu_flag_mask));
    check_eq({tag, "_flags"},32'(ccr_flags),     32'(alu_flags));
    check_eq({tag, "_busy"}, 32'(busy),          32'(0));
    check_eq({tag, "_ack"},  32'(intr_ack),      32'(0));
    check_eq({tag, "_done"}, 32'(rti_done),      32'(0));
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_nest"}, 32'(nest_level), 32'(m_stack.size()));
    check_eq({tag, "_ovf"},  32'(ovf_err),    32'(m_ovf));
    check_eq({tag, "_unf"},  32'(unf_err),    32'(m_unf));
    check_eq({tag, "_busy"}, 32'(busy),       32'(0));
  endtask

  // Interrupt entry; the pushed value is whatever ccr_q shows in the SAVE cycle.
  task automatic do_intr(input logic [3:0] v);
    rand_alu();
    ccr_q    = 4'($urandom);
    intr_req = 1'b1;
    #1;
    check_passthru("intr_idle");
    tick();
    if (m_stack.size() < DEPTH) begin
      intr_req      = 1'b0;
      ccr_q         = v;
      alu_flag_en   = 1'b1;
      alu_flag_mask = 4'($urandom);
      alu_flags     = 4'($urandom);
      #1;
      check_eq("save_ack",  32'(intr_ack), 32'(1));
      check_eq("save_busy", 32'(busy),     32'(1));
      check_eq("save_done", 32'(rti_done), 32'(0));
`ifdef CCR_CLEAR_ON_INTR_EN
      check_eq("save_en",    32'(ccr_flag_en),   32'(1));
      check_eq("save_mask",  32'(ccr_flag_mask), 32'(4'b1111));
      check_eq("save_flags", 32'(ccr_flags),     32'(4'b0000));
`else
      check_eq("save_en",    32'(ccr_flag_en),   32'(0));
`endif
      tick();
      m_stack.push_back(v);
      check_eq("save_ack_end", 32'(intr_ack), 32'(0));
    end else begin
      m_ovf = 1'b1;
      check_eq("ovf_no_ack", 32'(intr_ack), 32'(0));
      intr_req = 1'b0;
    end
    check_status("intr");
  endtask

  // RTI; optionally hold intr_req alongside to exercise priority.
  task automatic do_rti(input bit with_intr, input logic [3:0] v);
    rand_alu();
    rti_req  = 1'b1;
    intr_req = with_intr;
    ccr_q    = 4'($urandom);
    #1;
    check_passthru("rti_idle");
    tick();
    rti_req       = 1'b0;
    alu_flag_en   = 1'b1;
    alu_flag_mask = 4'($urandom);
    alu_flags     = 4'($urandom);
    #1;
    check_eq("rst_done",  32'(rti_done), 32'(1));
    check_eq("rst_ack",   32'(intr_ack), 32'(0));
    check_eq("rst_busy",  32'(busy),     32'(1));
    if (m_stack.size() > 0) begin
      check_eq("restore_en",    32'(ccr_flag_en),   32'(1));
      check_eq("restore_mask",  32'(ccr_flag_mask), 32'(4'b1111));
      check_eq("restore_flags", 32'(ccr_flags),     32'(m_stack[$]));
    end else begin
      check_eq("unf_en", 32'(ccr_flag_en), 32'(0));
    end
    tick();
    if (m_stack.size() > 0) begin
      void'(m_stack.pop_back());
    end else begin
      m_unf = 1'b1;
    end
    check_eq("rti_done_end", 32'(rti_done), 32'(0));
    check_status("rti");
    if (with_intr) begin
      do_intr(v);
    end
  endtask

  task automatic reset_mid_save();
    if (m_stack.size() < DEPTH) begin
      rand_alu();
      intr_req = 1'b1;
      #1;
      tick();
      intr_req    = 1'b0;
      rst         = 1'b1;
      alu_flag_en = 1'b1;
      #1;
      check_eq("rstsave_ack",  32'(intr_ack),    32'(0));
      check_eq("rstsave_en",   32'(ccr_flag_en), 32'(0));
      check_eq("rstsave_done", 32'(rti_done),    32'(0));
      tick();
      rst = 1'b0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check_status("rstsave");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    alu_flag_en   = 1'b1;
    alu_flag_mask = 4'b1111;
    alu_flags     = 4'b1010;
    ccr_q         = 4'b0000;
    intr_req      = 1'b0;
    rti_req       = 1'b0;
    m_ovf         = 1'b0;
    m_unf         = 1'b0;

    tick();
    check_eq("reset_en", 32'(ccr_flag_en), 32'(0));
    tick();
    rst         = 1'b0;
    alu_flag_en = 1'b0;
    #1;
    check_status("reset");
    check_eq("reset_idle_en", 32'(ccr_flag_en), 32'(0));

    alu_flag_en   = 1'b1;
    alu_flag_mask = 4'b0101;
    alu_flags     = 4'b1111;
    #1;
    check_passthru("passthru");
    tick();

    do_intr(4'b1010);
    do_rti(1'b0, 4'b0000);

    do_intr(4'b0001);
    do_intr(4'b0010);
    do_intr(4'b0100);
    do_intr(4'b1000);
    do_intr(4'b1111);
    for (int i = 0; i < 4; i++) begin
      do_rti(1'b0, 4'b0000);
    end

    do_rti(1'b0, 4'b0000);
    do_intr(4'b0011);
    do_rti(1'b1, 4'b0110);
    do_rti(1'b0, 4'b0000);

    do_intr(4'b0101);
    reset_mid_save();

    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op < 8) begin
        do_intr(4'($urandom));
      end else if (op < 14) begin
        do_rti(1'b0, 4'b0000);
      end else if (op < 17) begin
        do_rti(1'b1, 4'($urandom));
      end else if (op < 19) begin
        rand_alu();
        #1;
        check_passthru("rand_idle");
        tick();
      end else begin
        reset_mid_save();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
